// File: rtl/fork_block.sv
`default_nettype none
// ============================================================================
// Module   : fork_block
// Purpose  : Clocked four-phase handshake fork. One upstream req/ack channel
//            is broadcast to two downstream branches. The upstream ack is
//            raised only after both branches have acknowledged, and dropped
//            only after both branch acks have returned to zero. The payload
//            is captured on request acceptance and held for the transaction.
// Options  : FORK_TIMEOUT_EN - when defined, a watchdog counts the cycles
//            spent waiting in REQ/RTZ and raises a sticky timeout_err at
//            TIMEOUT_CYC. When undefined, timeout_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fork_block #(
  parameter int DATA_W      = 8,
  parameter int COUNT_W     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               req_in,
  output logic               ack_out,
  input  logic [DATA_W-1:0]  data_in,
  output logic               req_out1,
  output logic               req_out2,
  input  logic               ack_in1,
  input  logic               ack_in2,
  output logic [DATA_W-1:0]  data_out,
  output logic [COUNT_W-1:0] txn_count,
  output logic               timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_RTZ  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               got1_q, got1_d;
  logic               got2_q, got2_d;
  logic               low1_q, low1_d;
  logic               low2_q, low2_d;
  logic               req_q, req_d;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // State register plus all registered outputs and handshake bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      got1_q  <= 1'b0;
      got2_q  <= 1'b0;
      low1_q  <= 1'b0;
      low2_q  <= 1'b0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      got1_q  <= got1_d;
      got2_q  <= got2_d;
      low1_q  <= low1_d;
      low2_q  <= low2_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sticky per-branch flags decide when each phase is done
  always_comb begin
    state_d = state_q;
    got1_d  = got1_q;
    got2_d  = got2_q;
    low1_d  = low1_q;
    low2_d  = low2_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_in) begin
          data_d  = data_in;
          got1_d  = 1'b0;
          got2_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An ack seen once stays counted even if it drops again early;
        // a req_in drop here is a protocol violation and is ignored.
        got1_d = got1_q | ack_in1;
        got2_d = got2_q | ack_in2;
        if (got1_d && got2_d) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (!req_in) begin
          low1_d  = 1'b0;
          low2_d  = 1'b0;
          state_d = S_RTZ;
        end
      end
      S_RTZ: begin
        low1_d = low1_q | ~ack_in1;
        low2_d = low2_q | ~ack_in2;
        if (low1_d && low2_d) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + COUNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    req_d = (state_d == S_REQ)  || (state_d == S_FULL);
    ack_d = (state_d == S_FULL) || (state_d == S_RTZ);
  end

  assign req_out1  = req_q;
  assign req_out2  = req_q;
  assign ack_out   = ack_q;
  assign data_out  = data_q;
  assign txn_count = cnt_q;

`ifdef FORK_TIMEOUT_EN
  localparam int               TO_W     = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
  logic            waiting_d;

  // Watchdog registers; the error flag is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  // Restart on entry to a waiting state, count while staying, saturate at limit
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_err_d  = to_err_q;
    waiting_d = (state_d == S_REQ) || (state_d == S_RTZ);
    if (waiting_d && (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (waiting_d && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (waiting_d && (to_cnt_d == TO_LIMIT)) begin
      to_err_d = 1'b1;
    end
  end

  assign timeout_err = to_err_q;
`else
  // Watchdog not built; the limit parameter is intentionally left unused
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fork_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_fork_block
// Purpose  : Directed self-checking bench for fork_block. Two instances share
//            the same stimulus: one with default parameters and one with a
//            2-bit counter and a 10-cycle watchdog limit. A transaction-level
//            model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fork_block;

`ifdef FORK_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_in = 1'b0;
  logic       ack_in1 = 1'b0;
  logic       ack_in2 = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic        a_ack, a_r1, a_r2, a_err;
  logic [7:0]  a_data;
  logic [15:0] a_cnt;
  logic        b_ack, b_r1, b_r2, b_err;
  logic [7:0]  b_data;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fork_block #(.DATA_W(8), .COUNT_W(16), .TIMEOUT_CYC(255)) u_a (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(a_ack), .data_in(data_in),
    .req_out1(a_r1), .req_out2(a_r2), .ack_in1(ack_in1), .ack_in2(ack_in2),
    .data_out(a_data), .txn_count(a_cnt), .timeout_err(a_err)
  );

  fork_block #(.DATA_W(8), .COUNT_W(2), .TIMEOUT_CYC(10)) u_b (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(b_ack), .data_in(data_in),
    .req_out1(b_r1), .req_out2(b_r2), .ack_in1(ack_in1), .ack_in2(ack_in2),
    .data_out(b_data), .txn_count(b_cnt), .timeout_err(b_err)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level model ----------------
  bit         m_busy, m_need1, m_need2, m_released, m_up1, m_up2;
  bit         m_errA, m_errB;
  logic [7:0] m_data;
  int         m_count, m_wait;

  task automatic model_reset();
    m_busy = 0; m_need1 = 0; m_need2 = 0; m_released = 0; m_up1 = 0; m_up2 = 0;
    m_errA = 0; m_errB = 0; m_data = 8'h00; m_count = 0; m_wait = 0;
  endtask

  // Advance the model by one rising edge using the inputs that edge sampled
  task automatic model_edge();
    bit was_wait, now_wait, entered;
    entered  = 0;
    was_wait = m_busy && (m_need1 || m_need2 || m_released);
    if (!m_busy) begin
      if (req_in) begin
        m_busy = 1; m_need1 = 1; m_need2 = 1; m_released = 0;
        m_data = data_in; entered = 1;
      end
    end else if (m_need1 || m_need2) begin
      if (ack_in1) m_need1 = 0;
      if (ack_in2) m_need2 = 0;
    end else if (!m_released) begin
      if (!req_in) begin
        m_released = 1; m_up1 = 1; m_up2 = 1; entered = 1;
      end
    end else begin
      if (!ack_in1) m_up1 = 0;
      if (!ack_in2) m_up2 = 0;
      if (!m_up1 && !m_up2) begin
        m_busy = 0; m_released = 0; m_count++;
      end
    end
    now_wait = m_busy && (m_need1 || m_need2 || m_released);
    if (entered) m_wait = 0;
    else if (was_wait && now_wait) begin
      if (m_wait < 255) m_wait++;
      if (TO_ON && m_wait >= 10)  m_errB = 1;
      if (TO_ON && m_wait >= 255) m_errA = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, let the edge happen, update the model
  task automatic step(input bit r, input bit a1, input bit a2, input logic [7:0] d);
    req_in = r; ack_in1 = a1; ack_in2 = a2; data_in = d;
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic txn(input logic [7:0] d);
    step(1, 0, 0, d);
    step(1, 1, 1, d);
    step(0, 1, 1, d);
    step(0, 0, 0, d);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_req_out1", {31'd0, a_r1}, {31'd0, m_busy && !m_released});
      chk("a_req_out2", {31'd0, a_r2}, {31'd0, m_busy && !m_released});
      chk("a_ack_out",  {31'd0, a_ack}, {31'd0, m_busy && !(m_need1 || m_need2)});
      chk("a_data_out", {24'd0, a_data}, {24'd0, m_data});
      chk("a_txn_count", {16'd0, a_cnt}, m_count % 65536);
      chk("a_timeout_err", {31'd0, a_err}, {31'd0, m_errA});
      chk("b_req_out1", {31'd0, b_r1}, {31'd0, m_busy && !m_released});
      chk("b_req_out2", {31'd0, b_r2}, {31'd0, m_busy && !m_released});
      chk("b_ack_out",  {31'd0, b_ack}, {31'd0, m_busy && !(m_need1 || m_need2)});
      chk("b_data_out", {24'd0, b_data}, {24'd0, m_data});
      chk("b_txn_count", {30'd0, b_cnt}, m_count % 4);
      chk("b_timeout_err", {31'd0, b_err}, {31'd0, m_errB});
    end
  end

  initial begin
    model_reset();
    // reset state
    #2;
    chk("rst_ack_out", {31'd0, a_ack}, 32'd0);
    chk("rst_req_out", {31'd0, a_r1 | a_r2 | b_r1 | b_r2}, 32'd0);
    chk("rst_data_out", {24'd0, a_data}, 32'd0);
    chk("rst_txn_count", {16'd0, a_cnt}, 32'd0);
    #10 rst = 1'b1;
    chk_en = 1'b1;

    // basic transaction
    step(1, 0, 0, 8'hA5);
    chk("basic_req_up", {31'd0, a_r1 & a_r2}, 32'd1);
    chk("basic_data", {24'd0, a_data}, 32'hA5);
    step(1, 1, 1, 8'h00);
    chk("basic_ack_up", {31'd0, a_ack}, 32'd1);
    step(0, 1, 1, 8'h00);
    chk("basic_req_down", {31'd0, a_r1 | a_r2}, 32'd0);
    chk("basic_ack_held", {31'd0, a_ack}, 32'd1);
    step(0, 0, 0, 8'h00);
    chk("basic_ack_down", {31'd0, a_ack}, 32'd0);
    chk("basic_count", {16'd0, a_cnt}, 32'd1);
    step(0, 0, 0, 8'h00);

    // skewed acks with an early ack_in1 drop
    step(1, 0, 0, 8'h5A);
    step(1, 1, 0, 8'h5A);
    step(1, 1, 0, 8'h5A);
    step(1, 0, 0, 8'h5A);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h5A);
    chk("skew_ack_low", {31'd0, a_ack}, 32'd0);
    step(1, 0, 1, 8'h5A);
    chk("skew_ack_up", {31'd0, a_ack}, 32'd1);
    step(0, 0, 1, 8'h5A);
    step(0, 0, 0, 8'h5A);
    chk("skew_count", {16'd0, a_cnt}, 32'd2);
    chk("skew_data", {24'd0, a_data}, 32'h5A);

    // same-cycle acks and drops, with a long hold in each phase
    step(1, 0, 0, 8'h3C);
    step(1, 1, 1, 8'h3C);
    step(1, 1, 1, 8'h3C);
    step(0, 1, 1, 8'h3C);
    step(0, 1, 1, 8'h3C);
    chk("same_rtz_wait", {31'd0, a_ack}, 32'd1);
    step(0, 0, 0, 8'h3C);
    chk("same_count", {16'd0, a_cnt}, 32'd3);
    step(0, 0, 0, 8'h3C);
    chk("same_count_once", {16'd0, a_cnt}, 32'd3);

    // spurious ack in IDLE, then reset asserted while in FULL
    step(0, 0, 1, 8'h11);
    step(0, 0, 1, 8'h11);
    chk("spur_req", {31'd0, a_r1}, 32'd0);
    chk("spur_ack", {31'd0, a_ack}, 32'd0);
    step(1, 0, 0, 8'h77);
    step(1, 1, 1, 8'h77);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_ack", {31'd0, a_ack | b_ack}, 32'd0);
    chk("arst_req", {31'd0, a_r1 | a_r2}, 32'd0);
    chk("arst_data", {24'd0, a_data}, 32'd0);
    chk("arst_count", {16'd0, a_cnt}, 32'd0);
    step(1, 1, 1, 8'h77);
    step(0, 0, 1, 8'h77);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h77);
    chk("post_rst_ignore", {31'd0, a_r1 | a_ack}, 32'd0);
    step(0, 0, 0, 8'h00);

    // counter wrap on the 2-bit instance: 1,2,3,0,1
    txn(8'h01); chk("wrap_1", {30'd0, b_cnt}, 32'd1);
    txn(8'h02); chk("wrap_2", {30'd0, b_cnt}, 32'd2);
    txn(8'h03); chk("wrap_3", {30'd0, b_cnt}, 32'd3);
    txn(8'h04); chk("wrap_4", {30'd0, b_cnt}, 32'd0);
    txn(8'h05); chk("wrap_5", {30'd0, b_cnt}, 32'd1);
    chk("wrap_a", {16'd0, a_cnt}, 32'd5);
    step(0, 0, 0, 8'h00);

    // watchdog: ack_in2 withheld for 15 cycles in REQ, then completes
    step(1, 0, 0, 8'hEE);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 8'hEE);
    chk("to_not_yet", {31'd0, b_err}, 32'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 8'hEE);
    chk("to_b_err", {31'd0, b_err}, {31'd0, TO_ON});
    chk("to_a_err", {31'd0, a_err}, 32'd0);
    step(1, 1, 1, 8'hEE);
    chk("to_ack_up", {31'd0, b_ack}, 32'd1);
    step(0, 1, 1, 8'hEE);
    step(0, 0, 0, 8'hEE);
    step(0, 0, 0, 8'h00);
    chk("to_count", {30'd0, b_cnt}, 32'd2);
    chk("to_sticky", {31'd0, b_err}, {31'd0, TO_ON});

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fork_block.md
# fork_block

Clocked four-phase handshake fork: one upstream request/acknowledge channel is broadcast to two downstream channels, and the upstream acknowledge completes only after both branches have acknowledged. It is the splitting counterpart of the team's join stage and sits where one producer token must reach two consumers. The payload is registered on request capture and held stable for the whole transaction.

## Interface
- DATA_W, 8, payload width
- COUNT_W, 16, width of completed-transaction counter
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with FORK_TIMEOUT_EN)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_in  in  1  upstream request
- ack_out  out  1  upstream acknowledge
- data_in  in  DATA_W  upstream payload, stable while req_in=1
- req_out1 / req_out2  out  1  branch requests
- ack_in1 / ack_in2  in  1  branch acknowledges
- data_out  out  DATA_W  registered payload shared by both branches
- txn_count  out  COUNT_W  completed transactions, wraps
- timeout_err  out  1  sticky watchdog flag

## Operation
- Reset (rst=0, asynchronous): state IDLE; ack_out, req_out1, req_out2, timeout_err = 0; data_out, txn_count = 0; got1, got2, low1, low2 = 0.
- IDLE: when req_in=1, capture data_in into data_out, clear got1/got2, go to REQ.
- REQ: req_out1 = req_out2 = 1. Sticky got1/got2 set when ack_in1/ack_in2 sample 1. When got1&got2 (including both acks in the same cycle, or the second ack arriving), go to FULL.
- FULL: ack_out = 1, req_outs stay 1. When req_in samples 0, clear low1/low2, go to RTZ.
- RTZ: req_outs = 0, ack_out stays 1. Sticky low1/low2 set when ack_inN samples 0. When both are set, go to IDLE and increment txn_count mod 2^COUNT_W.
- ack_inN pulses outside REQ/RTZ are ignored; no state change.
- A branch whose ack drops early in REQ after being sampled high stays counted; got flags never clear within REQ.
- data_out changes only on the IDLE->REQ capture.
- A req_in drop during REQ is a protocol violation; the FSM ignores it and still waits for both acks.

## Timing
- All outputs are registered. No combinational path from input to output.
- req_in=1 sampled at edge k: data_out and req_out1/2 = 1 after edge k.
- Last required ack_inN=1 sampled at edge m: ack_out = 1 after edge m.
- req_in=0 sampled at edge p: req_out1/2 = 0 after edge p.
- Last required ack_inN=0 sampled at edge q: ack_out = 0 and txn_count+1 after edge q. A new req_in is accepted from edge q+1.
- Minimum transaction is 4 cycles with zero-latency partners.
- Asserting rst mid-transaction forces all outputs low immediately. A partner still holding ack high after reset release is ignored until REQ.

## Configuration
- FORK_TIMEOUT_EN defined: a counter of ceil(log2(TIMEOUT_CYC+1)) bits clears on entry to REQ and RTZ and increments each cycle spent there, saturating at the limit. Reaching TIMEOUT_CYC sets timeout_err, which holds until reset. The FSM keeps waiting and is not aborted.
- Not defined: no counter is built, and timeout_err is tied to 0.

## Test plan
- Basic transaction: data_in=0xA5 with req_in=1, both branches ack 1 cycle later and drop 1 cycle after req_outs fall -> data_out=0xA5, ack_out rises 1 cycle after acks, falls 1 cycle after both acks drop, txn_count=1.
- Skewed acks: ack_in1 at cycle 2, ack_in2 at cycle 9 -> ack_out stays 0 until the cycle after ack_in2. An ack_in1 drop at cycle 4 is not reflected.
- Same-cycle acks and same-cycle drops -> exactly one REQ->FULL and one RTZ->IDLE transition. Counter increments once.
- Spurious ack_in2=1 in IDLE, then reset asserted in FULL -> spurious ack ignored. After reset, all outputs are 0 immediately and txn_count=0.
- Wrap: COUNT_W=2, 5 back-to-back transactions -> txn_count sequence 1,2,3,0,1.
- FORK_TIMEOUT_EN, TIMEOUT_CYC=10, ack_in2 never asserted -> timeout_err=1 after 10 cycles in REQ and stays 1. A later ack_in2 completes the transaction normally. Without the macro, timeout_err stays 0.
